sync_down_timer: RTL
====================

// Module: sync_down_timer
// PURPOSE
//  Loadable synchronous down-counter/timer: the count-down counterpart of the team's synchronous up counter.
//  Counts from a programmed reload value to zero. Flags terminal count, then stops (one-shot) or reloads (periodic).
//  Counter bits are JK flip-flops in toggle mode, all clocked together; toggle enables are gated like the up counter, but on the zero-detect of lower bits.
//  Used as a tick/timeout generator for course peripherals.
// PARAMETERS
//  WIDTH   4   counter and reload width in bits (>=2)
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst_n      in   1      reset: asynchronous, active-low
//  load       in   1      write load_val into reload register (see BEHAVIOUR)
//  load_val   in   WIDTH  value written on load
//  start      in   1      start or restart counting from the reload register
//  stop       in   1      abort counting, return to IDLE, q holds
//  periodic   in   1      1: auto-reload at zero; 0: one-shot; sampled every cycle
//  q          out  WIDTH  current count
//  busy       out  1      1 while state==RUN
//  done       out  1      1 while state==DONE (one-shot expired)
//  tc         out  1      registered 1-cycle pulse: terminal count reached
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, q=0, reload=0, tc=0, busy=0, done=0.
//  States: IDLE, RUN, DONE. busy and done decode from registered state, so they add no extra latency.
//  Priority within a cycle: stop > start > count. load is independent of these.
//  load:
//   - In IDLE or DONE: reload<=load_val and q<=load_val at the same edge.
//   - In RUN: reload<=load_val only. q is unaffected; the new value applies at the next reload or start.
//  start (stop=0):
//   - From any state: q<=reload, state<=RUN.
//   - In RUN it restarts.
//   - If load is also asserted, start uses the old reload value.
//  stop: state<=IDLE; q holds; tc=0 that cycle.
//  RUN, no start/stop:
//   - q!=0: q<=q-1.
//   - q==0: tc<=1 at the next edge. Then, if periodic=1: q<=reload, stay RUN.
//     If periodic=0: state<=DONE, q stays 0.
//  Timing from the start edge:
//   - One-shot: tc fires reload+1 edges after q is loaded.
//   - Periodic: the tc period is reload+1 cycles.
//   - reload==0 with periodic=1: tc is high every cycle.
//  Wrap-around: q never decrements below 0 (no 0->all-ones wrap). Underflow is replaced by reload or DONE.
//  tc is 0 in every cycle not listed above. It never stays high for 2 cycles unless reload==0 and periodic=1.
//  Decrement structure: T[0]=en, T[i]=en & ~q[0] & ... & ~q[i-1].
//   - en = RUN & q!=0 & ~start & ~stop.
//   - Reload and load paths use the JK set/reset inputs per bit (j=v, k=~v).
//  Reset asserted mid-count: immediate return to reset values; tc must not glitch high.
// STRUCTURE
//  Shared package counters_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   - ST_RUN is the only encoding with bit0=1 (busy decode).
//  Sub-module jk_ff_n: JK flip-flop with async active-low reset to 0.
//   - 00 hold, 01 reset, 10 set, 11 toggle.
//   - WIDTH instances via generate.
//  FSM, reload register and tc register are behavioural in this module.
// TESTING (WIDTH=4)
//  1. Reset, load=1 val=3, then start, periodic=0 -> q 3,2,1,0 on successive edges; next edge tc=1 for one cycle, done=1, busy=0, q=0.
//  2. load 2, periodic=1, start -> tc every 3 cycles; q sequence 2,1,0,2,1,0...
//  3. In RUN at q=5 (reload 9), load val=4 -> q continues 4..0 from 5; after zero, q reloads to 4 (periodic).
//  4. start & stop same cycle in RUN at q=6 -> state IDLE, q=6, tc=0; later start alone -> q=reload.
//  5. load 0, periodic=1, start -> tc high every cycle, q stays 0, busy=1.
//  6. Drop rst_n asynchronously mid-count (q=7) -> q=0, busy=0, done=0, tc=0 before the next clk edge; release -> stays IDLE.

Source files
------------

// File: rtl/counters_pkg.sv
// counters_pkg: shared state encoding for the team's synchronous counters
package counters_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
    typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_RUN = ST_RUN, S_DONE = ST_DONE} state_t;
endpackage

// File: rtl/sync_down_timer_if.sv
// sync_down_timer_if: control and status bundle of the down timer
interface sync_down_timer_if #(parameter int WIDTH = 4);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             periodic;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;
    modport master (output load, load_val, start, stop, periodic, input q, busy, done, tc);
    modport slave  (input load, load_val, start, stop, periodic, output q, busy, done, tc);
endinterface

// File: rtl/jk_ff_n.sv
// jk_ff_n: JK flip-flop (00 hold, 01 reset, 10 set, 11 toggle), async active-low reset to 0
module jk_ff_n (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else        q <= (j & k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
endmodule

// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable one-shot/periodic down timer built from toggle-mode JK bits
module sync_down_timer import counters_pkg::*; #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             rst_n,
    sync_down_timer_if.slave bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] q, reload, wv;
    logic             tc, tc_n, go, run, zero, en, rl, ld, wr;
    always_comb begin
        go      = bus.start & ~bus.stop;
        run     = state[0];
        zero    = q == '0;
        en      = run & ~zero & ~bus.start & ~bus.stop;
        tc_n    = run & zero & ~bus.start & ~bus.stop;
        rl      = tc_n & bus.periodic;
        ld      = bus.load & ~run & ~go;
        wr      = go | rl | ld;
        wv      = (go | rl) ? reload : bus.load_val;
        state_n = bus.stop ? S_IDLE : bus.start ? S_RUN : (tc_n & ~bus.periodic) ? S_DONE : state;
    end
    // writes use J/K as set/reset; otherwise bit i toggles when all lower bits are zero
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam logic [WIDTH-1:0] LOW = WIDTH'((1 << i) - 1);
        logic t;
        assign t = en & ((q & LOW) == '0);
        jk_ff_n u_ff (.clk(clk), .rst_n(rst_n), .j(wr ? wv[i] : t), .k(wr ? ~wv[i] : t), .q(q[i]));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= S_IDLE;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state <= state_n;
            tc    <= tc_n;
            if (bus.load) reload <= bus.load_val;
        end
    assign bus.q    = q;
    assign bus.busy = state[0];
    assign bus.done = state == S_DONE;
    assign bus.tc   = tc;
endmodule
